// File: rtl/vec_reg_file_masked_pkg.sv
// Shared types and default geometry for the masked vector register file.
// Default sizes live here so the top and the lane array agree.
package vrf_pkg;

  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_VEC_LANES = 4;

  typedef enum logic {
    VRF_IDLE  = 1'b0,
    VRF_CLEAR = 1'b1
  } vrf_state_e;

endpackage

// File: rtl/vec_reg_file_masked_if.sv
// Port bundle of the masked vector register file: write, two reads, issue
// scoreboard and bulk-clear control, plus the clear FSM state for debug.
interface vec_reg_file_masked_if
  import vrf_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int VEC_LANES = DEF_VEC_LANES,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  localparam int SEL_W    = $clog2(NUM_REGS)
);

  logic                                 wr_en;
  logic [SEL_W-1:0]                     wr_sel;
  logic [VEC_LANES-1:0]                 wr_mask;
  logic [VEC_LANES-1:0][REG_WIDTH-1:0]  wr_data;
  logic [SEL_W-1:0]                     rd_sel1;
  logic [SEL_W-1:0]                     rd_sel2;
  logic [VEC_LANES-1:0][REG_WIDTH-1:0]  rd_data1;
  logic [VEC_LANES-1:0][REG_WIDTH-1:0]  rd_data2;
  logic                                 iss_en;
  logic [SEL_W-1:0]                     iss_sel;
  logic                                 pend1;
  logic                                 pend2;
  logic                                 clr_req;
  logic                                 clr_busy;
  logic                                 clr_done;
  vrf_state_e                           dbg_state;

  // Clear handshake: clr_req is sampled only while clr_busy=0; while clr_busy=1
  // wr_en/iss_en are dropped, so the producer must stall until clr_done.
  modport master (
    output wr_en, wr_sel, wr_mask, wr_data, rd_sel1, rd_sel2,
    output iss_en, iss_sel, clr_req,
    input  rd_data1, rd_data2, pend1, pend2, clr_busy, clr_done, dbg_state
  );

  modport slave (
    input  wr_en, wr_sel, wr_mask, wr_data, rd_sel1, rd_sel2,
    input  iss_en, iss_sel, clr_req,
    output rd_data1, rd_data2, pend1, pend2, clr_busy, clr_done, dbg_state
  );

endinterface

// File: rtl/vec_reg_file_masked_lane.sv
// One lane of the register file: NUM_REGS elements of REG_WIDTH bits with a
// write port and a synchronous single-register clear port.
module vrf_lane
  import vrf_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [SEL_W-1:0]                    wr_sel,
  input  logic [REG_WIDTH-1:0]                wr_data,
  input  logic                                clr_en,
  input  logic [SEL_W-1:0]                    clr_sel,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  rd_regs
);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] mem_q;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] mem_d;

  // The top never asserts both in one cycle; clear is given priority anyway.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_sel] = '0;
    end else if (wr_en) begin
      mem_d[wr_sel] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_regs = mem_q;

endmodule

// File: rtl/vec_reg_file_masked.sv
// Masked vector register file: per-lane write masks, write-to-read bypass,
// pending-write scoreboard and a one-register-per-cycle bulk clear.
module vec_reg_file_masked
  import vrf_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int VEC_LANES = DEF_VEC_LANES,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  vec_reg_file_masked_if.slave  bus
);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] lane_regs [VEC_LANES];

  vrf_state_e          state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic busy;
  logic wr_ok;
  logic byp1, byp2;
  logic [VEC_LANES-1:0][REG_WIDTH-1:0] rd1, rd2;

  assign busy  = (state_q == VRF_CLEAR);
  assign wr_ok = bus.wr_en && !busy;

  for (genvar j = 0; j < VEC_LANES; j++) begin : g_lane
    vrf_lane #(
      .NUM_REGS  (NUM_REGS),
      .REG_WIDTH (REG_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ok && bus.wr_mask[j]),
      .wr_sel  (bus.wr_sel),
      .wr_data (bus.wr_data[j]),
      .clr_en  (busy),
      .clr_sel (cnt_q),
      .rd_regs (lane_regs[j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      VRF_IDLE: begin
        if (bus.clr_req) begin
          state_d = VRF_CLEAR;
          cnt_d   = '0;
        end
      end
      VRF_CLEAR: begin
        if (cnt_q == SEL_W'(NUM_REGS - 1)) begin
          state_d = VRF_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = VRF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Issue is applied after the write-side clear so a same-register collision
  // leaves the entry pending.
  always_comb begin
    pend_d = pend_q;
    if (busy) begin
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (bus.wr_en) begin
        pend_d[bus.wr_sel] = 1'b0;
      end
      if (bus.iss_en) begin
        pend_d[bus.iss_sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= VRF_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  // Bypass is gated by reset so the read ports show zero while it is held.
  assign byp1 = wr_ok && reset && (bus.wr_sel == bus.rd_sel1);
  assign byp2 = wr_ok && reset && (bus.wr_sel == bus.rd_sel2);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int j = 0; j < VEC_LANES; j++) begin
      rd1[j] = (byp1 && bus.wr_mask[j]) ? bus.wr_data[j] : lane_regs[j][bus.rd_sel1];
      rd2[j] = (byp2 && bus.wr_mask[j]) ? bus.wr_data[j] : lane_regs[j][bus.rd_sel2];
    end
  end

  assign bus.rd_data1  = rd1;
  assign bus.rd_data2  = rd2;
  assign bus.pend1     = pend_q[bus.rd_sel1];
  assign bus.pend2     = pend_q[bus.rd_sel2];
  assign bus.clr_busy  = busy;
  assign bus.clr_done  = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_vec_reg_file_masked.sv
// Bench for vec_reg_file_masked: directed checks on the default geometry and a
// randomized run on a 16x8x16 instance against an array-based model.
module tb_vec_reg_file_masked;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vec_reg_file_masked_if #(.NUM_REGS(8), .VEC_LANES(4), .REG_WIDTH(8)) a_if ();
  vec_reg_file_masked_if #(.NUM_REGS(16), .VEC_LANES(8), .REG_WIDTH(16)) b_if ();

  vec_reg_file_masked #(.REG_WIDTH(8), .NUM_REGS(8), .VEC_LANES(4)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  vec_reg_file_masked #(.REG_WIDTH(16), .NUM_REGS(16), .VEC_LANES(8)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_if.wr_en   = 1'b0;
    a_if.wr_sel  = '0;
    a_if.wr_mask = '0;
    a_if.wr_data = '0;
    a_if.iss_en  = 1'b0;
    a_if.iss_sel = '0;
    a_if.clr_req = 1'b0;
  endtask

  task automatic a_write(input int sel, input logic [3:0] mask, input logic [31:0] data);
    a_if.wr_en   = 1'b1;
    a_if.wr_sel  = 3'(sel);
    a_if.wr_mask = mask;
    a_if.wr_data = data;
  endtask

  // Reference model for the 16-register instance.
  logic [15:0] bm [16][8];
  bit          bp [16];
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  bit          m_done = 1'b0;

  function automatic logic [127:0] b_expect(input int sel);
    logic [127:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      if (!m_busy && b_if.wr_en && int'(b_if.wr_sel) == sel && b_if.wr_mask[l])
        v[l*16 +: 16] = b_if.wr_data[l];
      else
        v[l*16 +: 16] = bm[sel][l];
    end
    return v;
  endfunction

  task automatic b_model_update();
    if (m_busy) begin
      for (int l = 0; l < 8; l++) bm[m_cnt][l] = '0;
      bp[m_cnt] = 1'b0;
      if (m_cnt == 15) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_cnt++;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (b_if.wr_en) begin
        for (int l = 0; l < 8; l++)
          if (b_if.wr_mask[l]) bm[b_if.wr_sel][l] = b_if.wr_data[l];
        bp[b_if.wr_sel] = 1'b0;
      end
      if (b_if.iss_en) bp[b_if.iss_sel] = 1'b1;
      if (b_if.clr_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  initial begin
    int run;
    a_idle();
    a_if.rd_sel1 = '0;
    a_if.rd_sel2 = '0;
    b_if.wr_en = 1'b0; b_if.wr_sel = '0; b_if.wr_mask = '0; b_if.wr_data = '0;
    b_if.iss_en = 1'b0; b_if.iss_sel = '0; b_if.clr_req = 1'b0;
    b_if.rd_sel1 = '0; b_if.rd_sel2 = '0;
    for (int r = 0; r < 16; r++) begin
      bp[r] = 1'b0;
      for (int l = 0; l < 8; l++) bm[r][l] = '0;
    end

    // Reset state, with a write presented that must not bypass.
    a_write(0, 4'hF, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd1", a_if.rd_data1, 0);
    check("rst_pend1", a_if.pend1, 0);
    check("rst_busy", a_if.clr_busy, 0);
    check("rst_done", a_if.clr_done, 0);
    a_idle();
    #1;
    reset = 1'b1;
    step();

    // Full write then masked overwrite.
    a_write(3, 4'hF, 32'h44332211);
    step();
    a_idle();
    a_if.rd_sel1 = 3'd3;
    #1;
    check("wr_full", a_if.rd_data1, 32'h44332211);
    a_write(3, 4'b0101, 32'hFFFFFFFF);
    step();
    a_idle();
    #1;
    check("wr_masked", a_if.rd_data1, 32'h44FF22FF);

    // Same-cycle bypass on port 2, then stored value.
    a_write(5, 4'b0011, 32'hAABBCCDD);
    a_if.rd_sel2 = 3'd5;
    #1;
    check("bypass_same", a_if.rd_data2, 32'h0000CCDD);
    step();
    a_idle();
    #1;
    check("bypass_after", a_if.rd_data2, 32'h0000CCDD);

    // Scoreboard set / collision / clear.
    a_if.rd_sel1 = 3'd2;
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd2;
    step();
    a_idle();
    #1;
    check("pend_set", a_if.pend1, 1);
    a_write(2, 4'b0000, 32'h12345678);
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd2;
    step();
    a_idle();
    #1;
    check("pend_collide", a_if.pend1, 1);
    check("mask0_nochange", a_if.rd_data1, 0);
    a_write(2, 4'b0000, 32'h0);
    step();
    a_idle();
    #1;
    check("pend_clr", a_if.pend1, 0);
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd6;
    step();
    a_write(6, 4'b0000, 32'h0);
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd4;
    step();
    a_idle();
    a_if.rd_sel1 = 3'd4;
    a_if.rd_sel2 = 3'd6;
    #1;
    check("pend_indep_set", a_if.pend1, 1);
    check("pend_indep_clr", a_if.pend2, 0);

    // Fill all registers, mark reg7 pending, then bulk clear.
    for (int r = 0; r < 8; r++) begin
      a_write(r, 4'hF, 32'h5A5A5A5A);
      step();
    end
    a_idle();
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd7;
    step();
    a_idle();
    a_if.rd_sel2 = 3'd7;
    #1;
    check("pre_clr_pend7", a_if.pend2, 1);
    a_if.clr_req = 1'b1;
    step();
    a_if.clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        a_write(1, 4'hF, 32'h11111111);
        a_if.rd_sel1 = 3'd1;
      end
      if (i == 7) a_if.clr_req = 1'b1;
      #1;
      check($sformatf("clr_busy_%0d", i), a_if.clr_busy, 1);
      check($sformatf("clr_nodone_%0d", i), a_if.clr_done, 0);
      if (i == 0) check("clr_no_bypass", a_if.rd_data1, 32'h5A5A5A5A);
      step();
      a_idle();
    end
    #1;
    check("clr_end_busy", a_if.clr_busy, 0);
    check("clr_done_pulse", a_if.clr_done, 1);
    step();
    check("clr_done_single", a_if.clr_done, 0);
    check("clr_req_late_ignored", a_if.clr_busy, 0);
    for (int r = 0; r < 8; r++) begin
      a_if.rd_sel1 = 3'(r);
      a_if.rd_sel2 = 3'(r);
      #1;
      check($sformatf("clr_reg%0d", r), a_if.rd_data1, 0);
      check($sformatf("clr_pend%0d", r), a_if.pend2, 0);
    end

    // Reset mid-clear.
    a_write(6, 4'hF, 32'h12345678);
    a_if.iss_en = 1'b1; a_if.iss_sel = 3'd6;
    step();
    a_idle();
    a_if.clr_req = 1'b1;
    step();
    a_if.clr_req = 1'b0;
    step();
    step();
    a_if.rd_sel1 = 3'd6;
    #1;
    check("mid_pre_data", a_if.rd_data1, 32'h12345678);
    check("mid_pre_pend", a_if.pend1, 1);
    check("mid_pre_busy", a_if.clr_busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_data", a_if.rd_data1, 0);
    check("mid_rst_pend", a_if.pend1, 0);
    check("mid_rst_busy", a_if.clr_busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_rst_nodone_%0d", i), a_if.clr_done, 0);
    end
    reset = 1'b1;
    step();
    check("post_rst_nodone", a_if.clr_done, 0);
    a_write(0, 4'b1000, 32'h7F000000);
    step();
    a_idle();
    a_if.rd_sel1 = 3'd0;
    #1;
    check("post_rst_write", a_if.rd_data1, 32'h7F000000);

    // Randomized run on the 16x8x16 instance.
    run = 0;
    for (int i = 0; i < 400; i++) begin
      b_if.wr_en   = ($urandom_range(0, 2) != 0);
      b_if.wr_sel  = 4'($urandom_range(0, 15));
      b_if.wr_mask = 8'($urandom_range(0, 255));
      for (int l = 0; l < 8; l++) b_if.wr_data[l] = 16'($urandom_range(0, 65535));
      b_if.iss_en  = ($urandom_range(0, 3) == 0);
      b_if.iss_sel = (b_if.wr_en && $urandom_range(0, 3) == 0) ? b_if.wr_sel
                                                               : 4'($urandom_range(0, 15));
      b_if.clr_req = (i == 20) || (i == 37) || ($urandom_range(0, 59) == 0);
      b_if.rd_sel1 = (($urandom_range(0, 1) == 0) ? b_if.wr_sel : 4'($urandom_range(0, 15)));
      b_if.rd_sel2 = 4'($urandom_range(0, 15));
      #1;
      check("b_rd1", b_if.rd_data1, b_expect(int'(b_if.rd_sel1)));
      check("b_rd2", b_if.rd_data2, b_expect(int'(b_if.rd_sel2)));
      check("b_pend1", b_if.pend1, bp[b_if.rd_sel1]);
      check("b_pend2", b_if.pend2, bp[b_if.rd_sel2]);
      check("b_busy", b_if.clr_busy, m_busy);
      check("b_done", b_if.clr_done, m_done);
      @(posedge clk);
      b_model_update();
      #1;
      if (b_if.clr_busy) begin
        run++;
      end else if (run != 0) begin
        check("b_busy_len", run, 16);
        run = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_reg_file_masked.md
Name: vec_reg_file_masked

Overview:
- Parametrised successor of the vector register file, sitting in the decoder stage of the vector ASIP.
- Provides NUM_REGS vector registers of VEC_LANES lanes × REG_WIDTH bits, with two combinational read ports and one write port.
- Adds per-lane write masking, write-to-read bypass, and a pending-write scoreboard for multi-cycle producers.
- Adds a sequenced bulk-clear engine that zeroes the file one register per cycle.

Parameters:
- REG_WIDTH, 8, bits per lane element.
- NUM_REGS, 8, number of vector registers; power of two, minimum 2.
- VEC_LANES, 4, lanes per vector.
- SEL_W, $clog2(NUM_REGS), register select width (derived; not overridden).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  write-port enable.
- wr_sel  in  SEL_W  destination register.
- wr_mask  in  VEC_LANES  per-lane write enable; bit j gates lane j.
- wr_data  in  VEC_LANES×REG_WIDTH  write data, lane-packed.
- rd_sel1  in  SEL_W  read port 1 select.
- rd_sel2  in  SEL_W  read port 2 select.
- rd_data1  out  VEC_LANES×REG_WIDTH  read port 1 data.
- rd_data2  out  VEC_LANES×REG_WIDTH  read port 2 data.
- iss_en  in  1  marks iss_sel as pending (long-latency producer issued).
- iss_sel  in  SEL_W  register to mark pending.
- pend1  out  1  pending bit of rd_sel1.
- pend2  out  1  pending bit of rd_sel2.
- clr_req  in  1  start bulk clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (reset=0, async): all registers, all lanes = 0; all pending bits = 0; FSM = IDLE; clear counter = 0; clr_busy = 0; clr_done = 0. With reset asserted, rd_data1/2 read 0 and pend1/2 = 0.
- Write: at posedge with wr_en=1 in IDLE, lane j of reg[wr_sel] ← wr_data[j] only where wr_mask[j]=1. Other lanes and registers hold. wr_mask=0 performs no data change but still clears the pending bit.
- Read: combinational, zero latency. Bypass: if wr_en=1, FSM=IDLE and wr_sel==rd_selN, lanes with wr_mask[j]=1 return wr_data[j]; unmasked lanes return stored data. Both ports may select the same register.
- Scoreboard: pending[iss_sel] set at posedge when iss_en=1; pending[wr_sel] cleared at posedge when wr_en=1. If both target the same register in the same cycle, set wins. Different targets update independently. pend1/pend2 come from flops only; no bypass.
- Clear FSM has two states:
  - IDLE: clr_req=1 → CLEAR with counter = 0 and clr_busy=1 from the next cycle.
  - CLEAR: each posedge zeroes all lanes of reg[counter], clears pending[counter] and increments counter. When counter = NUM_REGS-1, the final zeroing occurs, FSM → IDLE, clr_done = 1 for exactly the following cycle, and clr_busy falls in that same cycle. Duration is NUM_REGS cycles of clr_busy.
- While clr_busy=1:
  - wr_en and iss_en are ignored (dropped, not queued); upstream must stall.
  - Bypass is disabled.
  - clr_req is ignored.
  - Reads return current stored contents, so already-cleared registers read 0.
- clr_req asserted in the cycle the FSM returns to IDLE is ignored. A new clear requires clr_req in a cycle where clr_busy=0.
- Reset asserted mid-clear aborts immediately to the reset state; no clr_done pulse.
- Widths: no arithmetic on data; selects are exact SEL_W. The counter is SEL_W bits and its terminal compare is NUM_REGS-1, so no wrap is used.

Decomposition:
- Shared package vrf_pkg: state enum (VRF_IDLE, VRF_CLEAR) and default width constants (REG_WIDTH, NUM_REGS, VEC_LANES).
- One sub-module, vrf_lane: a single lane's NUM_REGS×REG_WIDTH flop array with async active-low reset, a write port (en, sel, data) and a sync-clear port (clr_en, clr_sel).
- The top level instantiates VEC_LANES copies and holds the scoreboard, bypass mux and clear FSM.
- Registers use data enables, not gated clocks.

Test Plan:
- Reset, then write reg3 = {0x44,0x33,0x22,0x11} with mask 4'b1111; next cycle rd_sel1=3 → 0x44332211. Then write reg3 = 0xFFFFFFFF with mask 4'b0101; next cycle rd_data1 = 0x44FF22FF.
- Bypass: wr_en=1, wr_sel=5, mask 4'b0011, data 0xAABBCCDD while reg5=0 and rd_sel2=5 → same-cycle rd_data2 = 0x0000CCDD; next cycle, with wr_en=0, rd_data2 = 0x0000CCDD.
- Scoreboard: iss_en on reg2 → pend1 (rd_sel1=2) = 1 next cycle. Same-cycle iss_en and wr_en on reg2 → pend1 stays 1. wr_en alone on reg2 → pend1 = 0 next cycle.
- Bulk clear with all registers at 0x5A5A5A5A, reg7 pending: pulse clr_req → clr_busy high for 8 cycles, clr_done single pulse after, every register reads 0, pend=0 for reg7. A wr_en to reg1 during busy is dropped (reg1 reads 0 after).
- Reset mid-clear (reset=0 at clear cycle 3) → all outputs 0 immediately, no clr_done. After release, a write to reg0 with mask 4'b1000 and data 0x7F000000 reads back 0x7F000000.
- Parameter sweep: NUM_REGS=16, VEC_LANES=8, REG_WIDTH=16. Random writes, masks and issues are checked against a scoreboard model, and clear takes exactly 16 busy cycles.
